stack_arbiter: RTL and testbench



---
 rtl/stack_arb_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/stack_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_stack_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_arb_pkg.sv
// -----------------------------------------------------------------------------
// stack_arb_pkg
// Shared definitions for the stack arbiter: controller state encoding,
// operation encoding, statistics counter width and a saturating-increment
// helper used by the optional statistics counters.
// -----------------------------------------------------------------------------
package stack_arb_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    localparam int STATS_W = 8;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] value);
        logic [STATS_W-1:0] result;
        if (value == {STATS_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(STATS_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector. Picks the first set request bit
// at or after the pointer position, wrapping from NREQ-1 back to 0. The
// pointer register itself lives in the parent.
//
// Ports:
//   req    in   NREQ   request vector
//   ptr    in   ID_W   highest-priority position for this round
//   grant  out  NREQ   one-hot grant (all zero when nothing requests)
//   id     out  ID_W   binary index of the granted requester
//   any    out  1      at least one request is set
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] id,
    output logic            any
);

    // Scan NREQ positions starting at ptr; the first hit wins.
    always_comb begin
        logic found_s;
        logic hit_s;
        int   idx_s;
        grant   = '0;
        id      = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        idx_s   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s        = (int'(ptr) + k) % NREQ;
            hit_s        = !found_s && req[idx_s];
            grant[idx_s] = hit_s;
            id           = hit_s ? ID_W'(idx_s) : id;
            found_s      = found_s | hit_s;
        end
        any = found_s;
    end

endmodule

// File: rtl/stack_arbiter.sv
// -----------------------------------------------------------------------------
// stack_arbiter
// Shares one LIFO stack between NREQ requesters. A round-robin grant accepts
// one request (ARB), the stack strobe is issued one cycle later (ISSUE) and a
// one-hot response pulse follows (RESP). Pushes into a full stack and pops
// from an empty stack are screened and answered with RSP_ERR instead of being
// forwarded. FULL/EMPTY are looked at during ISSUE only.
//
// Optional build macro: STACK_ARB_STATS_EN adds OP_COUNT / ERR_COUNT.
//
// Ports:
//   CLK, RST_N        clock (rising edge), asynchronous active-low reset
//   REQ_VALID/OP/DATA per-requester request (op 0 = push, 1 = pop)
//   REQ_READY         one-hot acceptance pulse
//   RSP_VALID         one-hot completion pulse
//   RSP_DATA, RSP_ERR popped value / rejection flag, valid with RSP_VALID
//   STK_PUSH/POP      stack strobes, STK_DATA_IN write data
//   STK_DATA_OUT      stack top-of-stack, STK_FULL / STK_EMPTY flags
//   OP_COUNT          (STACK_ARB_STATS_EN) saturating count of responses
//   ERR_COUNT         (STACK_ARB_STATS_EN) saturating count of rejections
// -----------------------------------------------------------------------------
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int DATA_W = 4
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [NREQ-1:0]          REQ_VALID,
    input  logic [NREQ-1:0]          REQ_OP,
    input  logic [NREQ*DATA_W-1:0]   REQ_DATA,
    output logic [NREQ-1:0]          REQ_READY,
    output logic [NREQ-1:0]          RSP_VALID,
    output logic [DATA_W-1:0]        RSP_DATA,
    output logic                     RSP_ERR,
    output logic                     STK_PUSH,
    output logic                     STK_POP,
    output logic [DATA_W-1:0]        STK_DATA_IN,
    input  logic [DATA_W-1:0]        STK_DATA_OUT,
    input  logic                     STK_FULL,
    input  logic                     STK_EMPTY
`ifdef STACK_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0]       OP_COUNT,
    output logic [STATS_W-1:0]       ERR_COUNT
`endif
);

    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t              state_r;
    state_t              state_s;
    logic [ID_W-1:0]     ptr_r;
    logic [ID_W-1:0]     id_r;
    logic                op_r;
    logic [DATA_W-1:0]   data_r;
    logic [NREQ-1:0]     rsp_valid_r;
    logic [DATA_W-1:0]   rsp_data_r;
    logic                rsp_err_r;

    logic [NREQ-1:0]     grant_s;
    logic [ID_W-1:0]     sel_id_s;
    logic                any_s;
    logic [NREQ-1:0]     ready_s;
    logic                push_s;
    logic                pop_s;
    logic                err_s;
    logic [DATA_W-1:0]   din_s;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr (
        .req   (REQ_VALID),
        .ptr   (ptr_r),
        .grant (grant_s),
        .id    (sel_id_s),
        .any   (any_s)
    );

    // Next-state and stack-side strobes; full/empty screening happens in ISSUE.
    always_comb begin
        state_s = state_r;
        ready_s = '0;
        push_s  = 1'b0;
        pop_s   = 1'b0;
        err_s   = 1'b0;
        din_s   = '0;
        case (state_r)
            ARB: begin
                if (any_s) begin
                    ready_s = grant_s;
                    state_s = ISSUE;
                end else begin
                    state_s = ARB;
                end
            end
            ISSUE: begin
                din_s = data_r;
                if (op_r == OP_PUSH) begin
                    if (!STK_FULL) begin
                        push_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    if (!STK_EMPTY) begin
                        pop_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                state_s = RESP;
            end
            RESP: begin
                state_s = ARB;
            end
            default: begin
                state_s = ARB;
            end
        endcase
    end

    // The acceptance pulse is combinational on REQ_VALID, so it is also
    // gated by reset to keep every output quiet while RST_N is low.
    assign REQ_READY   = ready_s & {NREQ{RST_N}};
    assign STK_PUSH    = push_s;
    assign STK_POP     = pop_s;
    assign STK_DATA_IN = din_s;
    assign RSP_VALID   = rsp_valid_r;
    assign RSP_DATA    = rsp_data_r;
    assign RSP_ERR     = rsp_err_r;

    // State, request latch, response registers and round-robin pointer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= ARB;
            ptr_r       <= '0;
            id_r        <= '0;
            op_r        <= 1'b0;
            data_r      <= '0;
            rsp_valid_r <= '0;
            rsp_data_r  <= '0;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            rsp_valid_r <= '0;
            rsp_data_r  <= '0;
            rsp_err_r   <= 1'b0;
            case (state_r)
                ARB: begin
                    if (any_s) begin
                        id_r   <= sel_id_s;
                        op_r   <= REQ_OP[sel_id_s];
                        data_r <= REQ_DATA[int'(sel_id_s)*DATA_W +: DATA_W];
                    end
                end
                ISSUE: begin
                    // Response is registered here so it appears exactly in RESP.
                    rsp_valid_r <= NREQ'(1'b1) << id_r;
                    rsp_data_r  <= pop_s ? STK_DATA_OUT : {DATA_W{1'b0}};
                    rsp_err_r   <= err_s;
                end
                RESP: begin
                    if (id_r == ID_W'(NREQ - 1)) begin
                        ptr_r <= '0;
                    end else begin
                        ptr_r <= id_r + {{(ID_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    ptr_r <= ptr_r;
                end
            endcase
        end
    end

`ifdef STACK_ARB_STATS_EN
    logic [STATS_W-1:0] op_cnt_r;
    logic [STATS_W-1:0] err_cnt_r;

    // Saturating counters of responses and of rejected responses.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_cnt_r  <= '0;
            err_cnt_r <= '0;
        end else if (state_r == RESP) begin
            op_cnt_r <= sat_inc(op_cnt_r);
            if (rsp_err_r) begin
                err_cnt_r <= sat_inc(err_cnt_r);
            end
        end
    end

    assign OP_COUNT  = op_cnt_r;
    assign ERR_COUNT = err_cnt_r;
`endif

endmodule

// File: tb/tb_stack_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stack_arbiter
// Directed, table-driven bench for stack_arbiter (NREQ = 2, DATA_W = 4).
// The bench plays the stack itself by driving FULL/EMPTY/DATA_OUT per vector.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_stack_arbiter;

    localparam int NREQ   = 2;
    localparam int DATA_W = 4;

    logic                   CLK;
    logic                   RST_N;
    logic [NREQ-1:0]        REQ_VALID;
    logic [NREQ-1:0]        REQ_OP;
    logic [NREQ*DATA_W-1:0] REQ_DATA;
    logic [NREQ-1:0]        REQ_READY;
    logic [NREQ-1:0]        RSP_VALID;
    logic [DATA_W-1:0]      RSP_DATA;
    logic                   RSP_ERR;
    logic                   STK_PUSH;
    logic                   STK_POP;
    logic [DATA_W-1:0]      STK_DATA_IN;
    logic [DATA_W-1:0]      STK_DATA_OUT;
    logic                   STK_FULL;
    logic                   STK_EMPTY;
`ifdef STACK_ARB_STATS_EN
    logic [7:0]             OP_COUNT;
    logic [7:0]             ERR_COUNT;
`endif

    stack_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .REQ_VALID    (REQ_VALID),
        .REQ_OP       (REQ_OP),
        .REQ_DATA     (REQ_DATA),
        .REQ_READY    (REQ_READY),
        .RSP_VALID    (RSP_VALID),
        .RSP_DATA     (RSP_DATA),
        .RSP_ERR      (RSP_ERR),
        .STK_PUSH     (STK_PUSH),
        .STK_POP      (STK_POP),
        .STK_DATA_IN  (STK_DATA_IN),
        .STK_DATA_OUT (STK_DATA_OUT),
        .STK_FULL     (STK_FULL),
        .STK_EMPTY    (STK_EMPTY)
`ifdef STACK_ARB_STATS_EN
        ,
        .OP_COUNT     (OP_COUNT),
        .ERR_COUNT    (ERR_COUNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            passed = passed + 1;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic [1:0] valid;
        logic [1:0] op;
        logic [7:0] data;
        logic       full;
        logic       empty;
        logic [3:0] top;
        logic [1:0] ready;  // expected grant, also the expected RSP_VALID
        logic       push;
        logic       pop;
        logic [3:0] din;
        logic [3:0] rdata;
        logic       err;
    } vec_t;

    vec_t vecs[9];

    // One full ARB -> ISSUE -> RESP transaction, checked at every step.
    task automatic run_vec(input int n, input vec_t v);
        REQ_VALID    = v.valid;
        REQ_OP       = v.op;
        REQ_DATA     = v.data;
        STK_FULL     = v.full;
        STK_EMPTY    = v.empty;
        STK_DATA_OUT = v.top;
        @(negedge CLK);
        chk($sformatf("v%0d ready", n), 32'(REQ_READY), 32'(v.ready));
        step();
        REQ_VALID = 2'b00;
        @(negedge CLK);
        chk($sformatf("v%0d push", n), 32'(STK_PUSH), 32'(v.push));
        chk($sformatf("v%0d pop", n), 32'(STK_POP), 32'(v.pop));
        chk($sformatf("v%0d din", n), 32'(STK_DATA_IN), 32'(v.din));
        chk($sformatf("v%0d no_early_rsp", n), 32'(RSP_VALID), 32'd0);
        step();
        @(negedge CLK);
        chk($sformatf("v%0d rsp_valid", n), 32'(RSP_VALID), 32'(v.ready));
        chk($sformatf("v%0d rsp_data", n), 32'(RSP_DATA), 32'(v.rdata));
        chk($sformatf("v%0d rsp_err", n), 32'(RSP_ERR), 32'(v.err));
        chk($sformatf("v%0d resp_strobes", n), 32'({STK_PUSH, STK_POP}), 32'd0);
        chk($sformatf("v%0d resp_din", n), 32'(STK_DATA_IN), 32'd0);
        step();
    endtask

    initial begin
        int grants;
        int order[6];
        int rsp_seen;

        //            valid  op     data   full  empty top   ready push  pop   din   rdata err
        vecs[0] = '{2'b01, 2'b00, 8'h0A, 1'b0, 1'b1, 4'h0, 2'b01, 1'b1, 1'b0, 4'hA, 4'h0, 1'b0};
        vecs[1] = '{2'b10, 2'b10, 8'h50, 1'b0, 1'b0, 4'hA, 2'b10, 1'b0, 1'b1, 4'h5, 4'hA, 1'b0};
        vecs[2] = '{2'b01, 2'b01, 8'h03, 1'b0, 1'b1, 4'h6, 2'b01, 1'b0, 1'b0, 4'h3, 4'h0, 1'b1};
        vecs[3] = '{2'b10, 2'b00, 8'h70, 1'b1, 1'b0, 4'h6, 2'b10, 1'b0, 1'b0, 4'h7, 4'h0, 1'b1};
        vecs[4] = '{2'b11, 2'b10, 8'h01, 1'b0, 1'b0, 4'h9, 2'b01, 1'b1, 1'b0, 4'h1, 4'h0, 1'b0};
        vecs[5] = '{2'b11, 2'b10, 8'h01, 1'b0, 1'b0, 4'h9, 2'b10, 1'b0, 1'b1, 4'h0, 4'h9, 1'b0};
        vecs[6] = '{2'b10, 2'b00, 8'hF0, 1'b0, 1'b0, 4'h9, 2'b10, 1'b1, 1'b0, 4'hF, 4'h0, 1'b0};
        vecs[7] = '{2'b01, 2'b01, 8'h00, 1'b0, 1'b0, 4'hC, 2'b01, 1'b0, 1'b1, 4'h0, 4'hC, 1'b0};
        vecs[8] = '{2'b01, 2'b00, 8'h02, 1'b0, 1'b0, 4'hC, 2'b01, 1'b1, 1'b0, 4'h2, 4'h0, 1'b0};

        // Reset state, with requests already pending.
        RST_N        = 1'b0;
        REQ_VALID    = 2'b11;
        REQ_OP       = 2'b00;
        REQ_DATA     = 8'h00;
        STK_DATA_OUT = 4'h0;
        STK_FULL     = 1'b0;
        STK_EMPTY    = 1'b1;
        @(negedge CLK);
        chk("rst ready", 32'(REQ_READY), 32'd0);
        chk("rst strobes", 32'({STK_PUSH, STK_POP}), 32'd0);
        chk("rst rsp", 32'({RSP_VALID, RSP_ERR, RSP_DATA}), 32'd0);
        chk("rst din", 32'(STK_DATA_IN), 32'd0);
`ifdef STACK_ARB_STATS_EN
        chk("rst counts", 32'({OP_COUNT, ERR_COUNT}), 32'd0);
`endif
        REQ_VALID = 2'b00;
        step();
        RST_N = 1'b1;
        step();

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // FULL sampled in ISSUE, not ARB; REQ_VALID ignored outside ARB.
        // Pointer is at 1 here, so only requester 0 is offered first.
        REQ_VALID = 2'b01;
        REQ_OP    = 2'b00;
        REQ_DATA  = 8'h0B;
        STK_FULL  = 1'b1;
        STK_EMPTY = 1'b0;
        @(negedge CLK);
        chk("late ready", 32'(REQ_READY), 32'b01);
        step();
        STK_FULL  = 1'b0;
        REQ_VALID = 2'b10;
        @(negedge CLK);
        chk("late push", 32'(STK_PUSH), 32'd1);
        chk("late din", 32'(STK_DATA_IN), 32'hB);
        chk("issue ignores valid", 32'(REQ_READY), 32'd0);
        step();
        STK_FULL = 1'b1;
        @(negedge CLK);
        chk("late rsp_err", 32'(RSP_ERR), 32'd0);
        chk("resp ignores valid", 32'(REQ_READY), 32'd0);
        step();
        REQ_VALID = 2'b00;
        STK_FULL  = 1'b0;
        step();

        // Reset during ISSUE of a push: strobe drops at once, no response.
        REQ_VALID = 2'b01;
        REQ_DATA  = 8'h0D;
        step();
        REQ_VALID = 2'b00;
        @(negedge CLK);
        chk("pre-rst push", 32'(STK_PUSH), 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("mid-rst push", 32'(STK_PUSH), 32'd0);
        chk("mid-rst din", 32'(STK_DATA_IN), 32'd0);
        step();
        chk("mid-rst rsp", 32'(RSP_VALID), 32'd0);
        RST_N = 1'b1;
        rsp_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            if (RSP_VALID != 2'b00) rsp_seen = rsp_seen + 1;
            step();
        end
        chk("no rsp after rst", 32'(rsp_seen), 32'd0);

        // Fairness: both continuously valid, pointer freshly reset to 0.
        REQ_VALID = 2'b11;
        REQ_OP    = 2'b11;
        STK_EMPTY = 1'b1;
        grants    = 0;
        for (int c = 0; c < 40 && grants < 6; c++) begin
            @(negedge CLK);
            if (REQ_READY == 2'b11) begin
                chk("ready overlap", 32'(REQ_READY), 32'b01);
            end
            if (REQ_READY != 2'b00) begin
                order[grants] = (REQ_READY == 2'b10) ? 1 : 0;
                grants = grants + 1;
            end
            step();
        end
        chk("fair grants", 32'(grants), 32'd6);
        for (int g = 0; g < 6; g++) begin
            chk($sformatf("fair order%0d", g), 32'(order[g]), 32'(g % 2));
        end
        REQ_VALID = 2'b00;
        step();
        step();
        step();

`ifdef STACK_ARB_STATS_EN
        // 300 pops on an empty stack saturate both counters.
        RST_N = 1'b0;
        step();
        RST_N     = 1'b1;
        REQ_VALID = 2'b01;
        REQ_OP    = 2'b01;
        STK_EMPTY = 1'b1;
        rsp_seen  = 0;
        for (int c = 0; c < 2000 && rsp_seen < 300; c++) begin
            @(negedge CLK);
            if (RSP_VALID != 2'b00) rsp_seen = rsp_seen + 1;
            step();
        end
        REQ_VALID = 2'b00;
        step();
        step();
        step();
        chk("stats rsp count", 32'(rsp_seen), 32'd300);
        chk("stats op_count", 32'(OP_COUNT), 32'd255);
        chk("stats err_count", 32'(ERR_COUNT), 32'd255);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
